// File: rtl/rv32_microprocessor.sv
// rtl/rv32_microprocessor.sv - single-cycle RV32I integer-ALU core (OP, OP-IMM, LUI)
module rv32_microprocessor #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] instruction,
  output logic [31:0] res_out,
  output logic [31:0] pc,
  output logic        reg_we
);

  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;

  logic [31:0] regs_q [32];
  logic [31:0] pc_q, pc_d;

  logic [6:0]  opcode, funct7;
  logic [2:0]  funct3;
  logic [4:0]  rd, rs1, rs2;
  logic [31:0] rs1_val, rs2_val, imm_i, op_b, result;
  logic [4:0]  shamt;
  logic        valid;

  assign opcode = instruction[6:0];
  assign rd     = instruction[11:7];
  assign funct3 = instruction[14:12];
  assign rs1    = instruction[19:15];
  assign rs2    = instruction[24:20];
  assign funct7 = instruction[31:25];
  assign imm_i  = {{20{instruction[31]}}, instruction[31:20]};

  assign rs1_val = (rs1 == 5'd0) ? 32'd0 : regs_q[rs1];
  assign rs2_val = (rs2 == 5'd0) ? 32'd0 : regs_q[rs2];

  // OP-IMM reuses the R-type datapath with the immediate standing in for rs2
  assign op_b  = (opcode == OPC_OP) ? rs2_val : imm_i;
  assign shamt = op_b[4:0];

  always_comb begin
    result = 32'd0;
    valid  = 1'b0;
    if (opcode == OPC_LUI) begin
      result = {instruction[31:12], 12'd0};
      valid  = 1'b1;
    end else if (opcode == OPC_OP || opcode == OPC_OP_IMM) begin
      // funct7[5] is only meaningful for SUB and SRA/SRAI; other funct7 patterns are NOPs
      if (opcode == OPC_OP) begin
        valid = (funct7 == 7'h00) ||
                (funct7 == 7'h20 && (funct3 == 3'd0 || funct3 == 3'd5));
      end else if (funct3 == 3'd1) begin
        valid = (funct7 == 7'h00);
      end else if (funct3 == 3'd5) begin
        valid = (funct7 == 7'h00) || (funct7 == 7'h20);
      end else begin
        valid = 1'b1;
      end
      case (funct3)
        3'd0: result = (opcode == OPC_OP && funct7[5]) ? rs1_val - op_b : rs1_val + op_b;
        3'd1: result = rs1_val << shamt;
        3'd2: result = {31'd0, $signed(rs1_val) < $signed(op_b)};
        3'd3: result = {31'd0, rs1_val < op_b};
        3'd4: result = rs1_val ^ op_b;
        3'd5: result = funct7[5] ? $unsigned($signed(rs1_val) >>> shamt) : rs1_val >> shamt;
        3'd6: result = rs1_val | op_b;
        3'd7: result = rs1_val & op_b;
        default: result = 32'd0;
      endcase
      if (!valid) result = 32'd0;
    end
  end

  assign res_out = rst ? 32'd0 : result;
  assign reg_we  = !rst && valid && (rd != 5'd0);
  assign pc_d    = pc_q + 32'd4;
  assign pc      = pc_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      pc_q <= RESET_PC;
      for (int i = 0; i < 32; i++) regs_q[i] <= 32'd0;
    end else begin
      pc_q <= pc_d;
      if (reg_we) regs_q[rd] <= res_out;
    end
  end

endmodule

// File: tb/tb_rv32_microprocessor.sv
// tb/tb_rv32_microprocessor.sv - directed self-checking bench for rv32_microprocessor
module tb_rv32_microprocessor;

  logic        clk;
  logic        rst;
  logic [31:0] instruction;
  logic [31:0] res_out;
  logic [31:0] pc;
  logic        reg_we;

  int tests = 0;
  int fails = 0;

  rv32_microprocessor #(.RESET_PC(32'h0000_0000)) dut (
    .clk(clk),
    .rst(rst),
    .instruction(instruction),
    .res_out(res_out),
    .pc(pc),
    .reg_we(reg_we)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Inputs change on the falling edge; outputs are sampled 1 time unit later
  task automatic run(input logic [31:0] ins);
    @(negedge clk);
    instruction = ins;
    #1;
  endtask

  initial begin
    rst = 1'b1;
    instruction = $urandom;
    @(negedge clk);
    #1;
    check("rst1_pc", pc, 32'h0);
    check("rst1_res", res_out, 32'h0);
    check("rst1_we", {31'd0, reg_we}, 32'd0);
    instruction = $urandom;
    @(negedge clk);
    #1;
    check("rst2_pc", pc, 32'h0);
    check("rst2_res", res_out, 32'h0);
    check("rst2_we", {31'd0, reg_we}, 32'd0);

    rst = 1'b0;
    instruction = 32'h01F002B3;
    #1;
    check("x31_zero", res_out, 32'h0);

    @(negedge clk);
    rst = 1'b1;
    instruction = 32'h00500093;
    #1;
    check("rstb_res", res_out, 32'h0);
    @(negedge clk);
    rst = 1'b0;

    instruction = 32'h00500093; #1;
    check("addi_x1", res_out, 32'd5);
    check("pc0", pc, 32'd0);
    check("addi_we", {31'd0, reg_we}, 32'd1);
    run(32'h00300113);
    check("addi_x2", res_out, 32'd3);
    check("pc4", pc, 32'd4);
    run(32'h002081B3);
    check("add_x3", res_out, 32'd8);
    check("pc8", pc, 32'd8);
    run(32'h40208233);
    check("sub_x4", res_out, 32'd2);
    check("pc12", pc, 32'd12);

    run(32'h00700013);
    check("pc16", pc, 32'd16);
    check("x0_we", {31'd0, reg_we}, 32'd0);
    run(32'h000002B3);
    check("x0_read", res_out, 32'd0);

    run(32'h FF800393);
    check("addi_neg", res_out, 32'hFFFFFFF8);
    run(32'h4013D413);
    check("srai", res_out, 32'hFFFFFFFC);
    run(32'h0013D493);
    check("srli", res_out, 32'h7FFFFFFC);
    run(32'h0070B533);
    check("sltu", res_out, 32'd1);
    run(32'h0013A5B3);
    check("slt", res_out, 32'd1);
    run(32'h0FF3C813);
    check("xori", res_out, 32'hFFFFFF07);
    run(32'h002097B3);
    check("sll", res_out, 32'h28);
    check("pc48", pc, 32'd48);
    run(32'h402097B3);
    check("bad_funct_res", res_out, 32'd0);
    check("bad_funct_we", {31'd0, reg_we}, 32'd0);

    run(32'h12345337);
    check("lui", res_out, 32'h12345000);
    run(32'h00000000);
    check("ill_res", res_out, 32'd0);
    check("ill_we", {31'd0, reg_we}, 32'd0);
    check("ill_pc", pc, 32'd60);
    run(32'h000086B3);
    check("x1_kept", res_out, 32'd5);
    check("ill_pc_next", pc, 32'd64);
    run(32'h00030733);
    check("x6_kept", res_out, 32'h12345000);

    @(negedge clk);
    rst = 1'b1;
    instruction = 32'h00008633;
    #1;
    check("mid_rst_res", res_out, 32'd0);
    check("mid_rst_we", {31'd0, reg_we}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("mid_rst_pc", pc, 32'd0);
    check("mid_rst_x1", res_out, 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
